fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues req/ack reads to instruction memory, and loads the IF/ID register (if_id_instruc, if_id_nextpc) that feeds Decode.

---
 rtl/fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_fetch_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues req/ack reads to instruction memory
// and loads the IF/ID register, with one architectural delay slot and a 1-entry skid.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_stall,
    input  logic        id_if_selpcsource,
    input  logic [1:0]  id_if_selpctype,
    input  logic [31:0] id_if_pcimd2ext,
    input  logic [31:0] id_if_pcindex,
    input  logic [31:0] id_if_rega,
    output logic        if_mem_req,
    output logic [31:0] if_mem_addr,
    input  logic        mem_if_ack,
    input  logic [31:0] mem_if_data,
    output logic [31:0] if_id_instruc,
    output logic [31:0] if_id_nextpc,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] instruc_q, instruc_d;
    logic [31:0] nextpc_q, nextpc_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_nextpc_q, skid_nextpc_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;

    logic [31:0] target_raw_s;
    logic [31:0] target_s;
    logic [31:0] pc_plus4_s;
    logic        fetch_acc_s;
    logic        redir_take_s;

    // Redirect target selection; low bits cleared so fetches stay word aligned
    always_comb begin
        target_raw_s = EXC_VECTOR;
        case (id_if_selpctype)
            2'b00:   target_raw_s = id_if_pcimd2ext;
            2'b01:   target_raw_s = id_if_pcindex;
            2'b10:   target_raw_s = id_if_rega;
            2'b11:   target_raw_s = EXC_VECTOR;
            default: target_raw_s = EXC_VECTOR;
        endcase
        target_s = target_raw_s & 32'hFFFF_FFFC;
    end

    assign pc_plus4_s   = pc_q + 32'd4;
    // ack only counts while a request is actually on the bus
    assign fetch_acc_s  = (state_q == ST_FETCH) && mem_if_ack;
    // Decode's redirect is only meaningful on the edge its instruction advances
    assign redir_take_s = id_if_selpcsource && !if_stall && valid_q;

    // Next-state, PC, IF/ID, skid and pending-redirect logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instruc_d     = instruc_q;
        nextpc_d      = nextpc_q;
        valid_d       = valid_q;
        skid_instr_d  = skid_instr_q;
        skid_nextpc_d = skid_nextpc_q;
        redir_pend_d  = redir_pend_q;
        redir_tgt_d   = redir_tgt_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (fetch_acc_s && if_stall) begin
                    state_d       = ST_HOLD;
                    skid_instr_d  = mem_if_data;
                    skid_nextpc_d = pc_plus4_s;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (!if_stall) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (!if_stall) begin
            if (state_q == ST_HOLD) begin
                instruc_d = skid_instr_q;
                nextpc_d  = skid_nextpc_q;
                valid_d   = 1'b1;
            end else if (fetch_acc_s) begin
                instruc_d = mem_if_data;
                nextpc_d  = pc_plus4_s;
                valid_d   = 1'b1;
            end else begin
                instruc_d = NOP_INSTR;
                valid_d   = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end

        // The fetch accepted alongside or after a redirect is the delay slot
        if (fetch_acc_s) begin
            if (redir_take_s) begin
                pc_d = target_s;
            end else if (redir_pend_q) begin
                pc_d = redir_tgt_q;
            end else begin
                pc_d = pc_plus4_s;
            end
            redir_pend_d = 1'b0;
        end else if (redir_take_s) begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = target_s;
        end else begin
            redir_pend_d = redir_pend_q;
        end

        req_d = (state_d == ST_FETCH);
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            req_q         <= 1'b0;
            instruc_q     <= NOP_INSTR;
            nextpc_q      <= RESET_PC;
            valid_q       <= 1'b0;
            skid_instr_q  <= NOP_INSTR;
            skid_nextpc_q <= RESET_PC;
            redir_pend_q  <= 1'b0;
            redir_tgt_q   <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_q         <= req_d;
            instruc_q     <= instruc_d;
            nextpc_q      <= nextpc_d;
            valid_q       <= valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_nextpc_q <= skid_nextpc_d;
            redir_pend_q  <= redir_pend_d;
            redir_tgt_q   <= redir_tgt_d;
        end
    end

    assign if_mem_req    = req_q;
    assign if_mem_addr   = pc_q;
    assign if_id_instruc = instruc_q;
    assign if_id_nextpc  = nextpc_q;
    assign if_id_valid   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory responder, Decode redirect driver and
// a scoreboard of expected fetch addresses and IF/ID contents.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] nextpc;
    } ifid_t;

    logic        clock;
    logic        reset;
    logic        if_stall;
    logic        id_if_selpcsource;
    logic [1:0]  id_if_selpctype;
    logic [31:0] id_if_pcimd2ext;
    logic [31:0] id_if_pcindex;
    logic [31:0] id_if_rega;
    logic        if_mem_req;
    logic [31:0] if_mem_addr;
    logic        mem_if_ack;
    logic [31:0] mem_if_data;
    logic [31:0] if_id_instruc;
    logic [31:0] if_id_nextpc;
    logic        if_id_valid;

    fetch_stage dut (
        .clock             (clock),
        .reset             (reset),
        .if_stall          (if_stall),
        .id_if_selpcsource (id_if_selpcsource),
        .id_if_selpctype   (id_if_selpctype),
        .id_if_pcimd2ext   (id_if_pcimd2ext),
        .id_if_pcindex     (id_if_pcindex),
        .id_if_rega        (id_if_rega),
        .if_mem_req        (if_mem_req),
        .if_mem_addr       (if_mem_addr),
        .mem_if_ack        (mem_if_ack),
        .mem_if_data       (mem_if_data),
        .if_id_instruc     (if_id_instruc),
        .if_id_nextpc      (if_id_nextpc),
        .if_id_valid       (if_id_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_chk;
    int          n_pass;
    ifid_t       exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic        boot;
    logic        shown_valid;
    logic [31:0] shown_instr;
    logic [31:0] shown_nextpc;
    logic        br_armed;
    logic [31:0] br_pc;
    logic [1:0]  br_type;
    logic [31:0] br_imm;
    logic [31:0] br_idx;
    logic [31:0] br_rega;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic arm(input logic [31:0] pc, input logic [1:0] typ, input logic [31:0] imm,
                       input logic [31:0] idx, input logic [31:0] rega);
        br_armed = 1'b1;
        br_pc    = pc;
        br_type  = typ;
        br_imm   = imm;
        br_idx   = idx;
        br_rega  = rega;
    endtask

    // One clock: drive memory/Decode/stall, check req and address, then check IF/ID after the edge
    task automatic cycle(input logic ack, input logic stall);
        logic        exp_req;
        logic [31:0] a;
        ifid_t       e;
        if_stall          = stall;
        mem_if_ack        = ack;
        mem_if_data       = mem_word(if_mem_addr);
        id_if_selpctype   = br_type;
        id_if_pcimd2ext   = br_imm;
        id_if_pcindex     = br_idx;
        id_if_rega        = br_rega;
        id_if_selpcsource = br_armed && shown_valid && (shown_nextpc == br_pc + 32'd4);
        exp_req = !boot && (exp_q.size() == 0);
        check1("mem_req", if_mem_req, exp_req);
        if (ack && exp_req) begin
            if (exp_addr_q.size() != 0) a = exp_addr_q.pop_front();
            else a = 32'hxxxx_xxxx;
            check32("fetch_addr", if_mem_addr, a);
            e.instr  = mem_word(a);
            e.nextpc = a + 32'd4;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
        boot = 1'b0;
        if (id_if_selpcsource && !stall) br_armed = 1'b0;
        if (!stall) begin
            if (exp_q.size() != 0) begin
                e            = exp_q.pop_front();
                shown_valid  = 1'b1;
                shown_instr  = e.instr;
                shown_nextpc = e.nextpc;
            end else begin
                shown_valid = 1'b0;
                shown_instr = NOP;
            end
        end
        check32("ifid_instruc", if_id_instruc, shown_instr);
        check32("ifid_nextpc", if_id_nextpc, shown_nextpc);
        check1("ifid_valid", if_id_valid, shown_valid);
        id_if_selpcsource = 1'b0;
    endtask

    task automatic run(input int n, input logic ack, input logic stall);
        for (int i = 0; i < n; i++) cycle(ack, stall);
    endtask

    task automatic push_addr(input logic [31:0] a);
        exp_addr_q.push_back(a);
    endtask

    task automatic check_drained(input string tag);
        check32(tag, 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic do_reset(input logic boot_ack);
        reset             = 1'b1;
        mem_if_ack        = 1'b0;
        if_stall          = 1'b0;
        id_if_selpcsource = 1'b0;
        @(posedge clock);
        #1;
        exp_q.delete();
        exp_addr_q.delete();
        br_armed     = 1'b0;
        shown_valid  = 1'b0;
        shown_instr  = NOP;
        shown_nextpc = 32'h0000_0000;
        boot         = 1'b1;
        check1("rst_req", if_mem_req, 1'b0);
        check32("rst_addr", if_mem_addr, 32'h0000_0000);
        check32("rst_instruc", if_id_instruc, NOP);
        check32("rst_nextpc", if_id_nextpc, 32'h0000_0000);
        check1("rst_valid", if_id_valid, 1'b0);
        reset = 1'b0;
        cycle(boot_ack, 1'b0);
    endtask

    initial begin
        n_chk             = 0;
        n_pass            = 0;
        reset             = 1'b1;
        if_stall          = 1'b0;
        mem_if_ack        = 1'b0;
        mem_if_data       = 32'h0000_0000;
        id_if_selpcsource = 1'b0;
        id_if_selpctype   = 2'b00;
        id_if_pcimd2ext   = 32'h0000_0000;
        id_if_pcindex     = 32'h0000_0000;
        id_if_rega        = 32'h0000_0000;
        boot              = 1'b1;
        shown_valid       = 1'b0;
        shown_instr       = NOP;
        shown_nextpc      = 32'h0000_0000;
        br_armed          = 1'b0;
        br_pc             = 32'h0000_0000;
        br_type           = 2'b00;
        br_imm            = 32'h0000_0000;
        br_idx            = 32'h0000_0000;
        br_rega           = 32'h0000_0000;

        // Reset, streaming fetch, then a taken branch at 0x8 with its delay slot
        do_reset(1'b0);
        arm(32'h0000_0008, 2'b00, 32'h0000_0040, 32'h0BAD_0010, 32'h0BAD_0020);
        push_addr(32'h0000_0000); push_addr(32'h0000_0004); push_addr(32'h0000_0008);
        push_addr(32'h0000_000C); push_addr(32'h0000_0040); push_addr(32'h0000_0044);
        push_addr(32'h0000_0048);
        run(7, 1'b1, 1'b0);
        check_drained("t2_drain");

        // Branch at 0x50 whose delay-slot ack arrives late; target low bits are cleared
        arm(32'h0000_0050, 2'b00, 32'h0000_0101, 32'h0BAD_0030, 32'h0BAD_0040);
        push_addr(32'h0000_004C); push_addr(32'h0000_0050); push_addr(32'h0000_0054);
        push_addr(32'h0000_0100); push_addr(32'h0000_0104);
        run(2, 1'b1, 1'b0);
        run(3, 1'b0, 1'b0);
        run(3, 1'b1, 1'b0);
        check_drained("t3_drain");

        // Stall with no ack, then stall while a fetch completes into the skid
        push_addr(32'h0000_0108); push_addr(32'h0000_010C); push_addr(32'h0000_0110);
        run(1, 1'b0, 1'b1);
        run(4, 1'b1, 1'b1);
        run(3, 1'b1, 1'b0);
        check_drained("t4_drain");

        // jr through rega, then exception vector, then a jump through pcindex
        arm(32'h0000_0114, 2'b10, 32'h0BAD_0050, 32'h0BAD_0060, 32'h0000_1003);
        push_addr(32'h0000_0114); push_addr(32'h0000_0118); push_addr(32'h0000_1000);
        run(3, 1'b1, 1'b0);
        arm(32'h0000_1004, 2'b11, 32'h0BAD_0070, 32'h0BAD_0080, 32'h0BAD_0090);
        push_addr(32'h0000_1004); push_addr(32'h0000_1008); push_addr(32'h0000_0080);
        push_addr(32'h0000_0084);
        run(4, 1'b1, 1'b0);
        arm(32'h0000_0088, 2'b01, 32'h0BAD_00A0, 32'h0000_2002, 32'h0BAD_00B0);
        push_addr(32'h0000_0088); push_addr(32'h0000_008C); push_addr(32'h0000_2000);
        push_addr(32'h0000_2004);
        run(4, 1'b1, 1'b0);
        check_drained("t5_drain");

        // PC wrap from the top of the address space
        arm(32'h0000_2008, 2'b10, 32'h0BAD_00C0, 32'h0BAD_00D0, 32'hFFFF_FFFF);
        push_addr(32'h0000_2008); push_addr(32'h0000_200C); push_addr(32'hFFFF_FFFC);
        push_addr(32'h0000_0000); push_addr(32'h0000_0004);
        run(5, 1'b1, 1'b0);
        check_drained("wrap_drain");

        // Reset with a request outstanding; the late ack lands in BOOT and is dropped
        do_reset(1'b1);
        push_addr(32'h0000_0000); push_addr(32'h0000_0004);
        run(2, 1'b1, 1'b0);
        check_drained("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
